// File: rtl/carry_forward_generator.sv
// carry_forward_generator: registered 4-bit carry-lookahead generator.
// Carries are computed in flat two-level lookahead form from bit-level
// generate/propagate terms and registered one cycle after an accepted request.
// Optional feature macro: CFG_GROUP_PG_EN adds registered group propagate
// (grp_p) and group generate (grp_g) outputs.
module carry_forward_generator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] cout,
`ifdef CFG_GROUP_PG_EN
    output logic       out_valid,
    output logic       grp_p,
    output logic       grp_g
`else
    output logic       out_valid
`endif
);

    localparam int unsigned W = 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] carry_c;
`ifdef CFG_GROUP_PG_EN
    logic         grp_p_c;
    logic         grp_g_c;
`endif

    // Bit generate/propagate terms and flat lookahead carries (no ripple chain).
    always_comb begin
        g = a & b;
        p = a ^ b;

        carry_c[0] = g[0]
                   | (p[0] & cin);
        carry_c[1] = g[1]
                   | (p[1] & g[0])
                   | (p[1] & p[0] & cin);
        carry_c[2] = g[2]
                   | (p[2] & g[1])
                   | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cin);
        carry_c[3] = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & cin);
    end

`ifdef CFG_GROUP_PG_EN
    // Group terms for a second-level lookahead unit; independent of cin.
    always_comb begin
        grp_p_c = &p;
        grp_g_c = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    end
`endif

    // Result registers: capture on a valid request, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout      <= W'(0);
            out_valid <= 1'b0;
`ifdef CFG_GROUP_PG_EN
            grp_p     <= 1'b0;
            grp_g     <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                cout  <= carry_c;
`ifdef CFG_GROUP_PG_EN
                grp_p <= grp_p_c;
                grp_g <= grp_g_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_carry_forward_generator.sv
// Self-checking bench for carry_forward_generator: directed vectors, async
// reset, random traffic and an exhaustive sweep against an arithmetic model.
// Define CFG_GROUP_PG_EN to also check grp_p/grp_g.
module tb_carry_forward_generator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] cout;
    logic       out_valid;
`ifdef CFG_GROUP_PG_EN
    logic       grp_p;
    logic       grp_g;
`endif

    int checks;
    int errors;
    int valid_cycles;

    // Reference state
    logic [3:0] exp_cout;
    logic       exp_valid;
    logic       exp_gp;
    logic       exp_gg;

    carry_forward_generator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .cout      (cout),
`ifdef CFG_GROUP_PG_EN
        .out_valid (out_valid),
        .grp_p     (grp_p),
        .grp_g     (grp_g)
`else
        .out_valid (out_valid)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Carry out of bit i of a+b+cin, from integer addition of the low i+1 bits.
    function automatic logic [3:0] ref_carry(input logic [3:0] ra, input logic [3:0] rb,
                                             input logic rc);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int m;
            int s;
            m = 1 << (i + 1);
            s = (int'(ra) % m) + (int'(rb) % m) + int'(rc);
            r[i] = (s >= m);
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".cout"}, 8'(cout), 8'(exp_cout));
        check({tag, ".out_valid"}, 8'(out_valid), 8'(exp_valid));
`ifdef CFG_GROUP_PG_EN
        check({tag, ".grp_p"}, 8'(grp_p), 8'(exp_gp));
        check({tag, ".grp_g"}, 8'(grp_g), 8'(exp_gg));
`endif
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, check after it.
    task automatic cycle(input string tag, input logic v, input logic [3:0] va,
                         input logic [3:0] vb, input logic vc);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
        @(posedge clk);
        if (!rst_n) begin
            exp_cout  = 4'b0000;
            exp_valid = 1'b0;
            exp_gp    = 1'b0;
            exp_gg    = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                exp_cout = ref_carry(va, vb, vc);
                exp_gp   = ((va ^ vb) == 4'hF);
                exp_gg   = ((int'(va) + int'(vb)) >= 16);
            end
        end
        #1;
        if (out_valid === 1'b1) valid_cycles++;
        check_outputs(tag);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        valid_cycles = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = 4'h0;
        b            = 4'h0;
        cin          = 1'b0;
        exp_cout     = 4'b0000;
        exp_valid    = 1'b0;
        exp_gp       = 1'b0;
        exp_gg       = 1'b0;

        #3;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: single pulse then idle hold
        cycle("t1110_0111", 1'b1, 4'b1110, 4'b0111, 1'b0);
        check("t1110_0111.lit", 8'(cout), 8'b1110);
        cycle("idle_hold", 1'b0, 4'h0, 4'h0, 1'b0);

        // Four back to back, then idle
        valid_cycles = 0;
        cycle("t1001_1101", 1'b1, 4'b1001, 4'b1101, 1'b0);
        check("t1001_1101.lit", 8'(cout), 8'b1001);
        cycle("t0110_1100", 1'b1, 4'b0110, 4'b1100, 1'b1);
        check("t0110_1100.lit", 8'(cout), 8'b1100);
        cycle("t0111_1110", 1'b1, 4'b0111, 4'b1110, 1'b1);
        check("t0111_1110.lit", 8'(cout), 8'b1111);
        cycle("t1111_0000", 1'b1, 4'b1111, 4'b0000, 1'b1);
        check("t1111_0000.lit", 8'(cout), 8'b1111);
        for (int i = 0; i < 3; i++) cycle("b2b_idle", 1'b0, 4'(i), 4'(i + 5), 1'b1);
        check("b2b_valid_cycles", 8'(valid_cycles), 8'd4);
        check("b2b_hold.lit", 8'(cout), 8'b1111);

        // Random traffic
        for (int i = 0; i < 200; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom));

        // Async reset mid-stream, with a request present during reset
        cycle("pre_rst", 1'b1, 4'b1111, 4'b0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cout  = 4'b0000;
        exp_valid = 1'b0;
        exp_gp    = 1'b0;
        exp_gg    = 1'b0;
        check_outputs("async_rst");
        cycle("rst_discard", 1'b1, 4'b1111, 4'b1111, 1'b1);
        rst_n = 1'b1;
        cycle("post_rst", 1'b1, 4'b0101, 4'b0011, 1'b0);
        cycle("post_rst_idle", 1'b0, 4'h0, 4'h0, 1'b0);

        // Exhaustive sweep, back to back
        for (int i = 0; i < 512; i++)
            cycle("sweep", 1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
        cycle("sweep_end", 1'b0, 4'h0, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
